// File: rtl/lif_neuron.sv
// Leaky integrate-and-fire neuron fed by the MAC weighted sum.
// Each accepted sample leaks the membrane potential by vmem>>>LEAK_SHIFT,
// adds the signed input with saturation, and fires a one-cycle spike when
// the result reaches THRESH. A refractory window then discards REFRAC
// samples. A saturating spike counter is kept for readout.
module lif_neuron #(
    parameter int IN_WIDTH   = 8,
    parameter int VM_WIDTH   = 12,
    parameter int THRESH     = 100,
    parameter int V_RESET    = 0,
    parameter int LEAK_SHIFT = 4,
    parameter int REFRAC     = 2,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clear,
    input  logic                 in_valid,
    input  logic [IN_WIDTH-1:0]  syn_in,
    output logic                 spike_out,
    output logic [VM_WIDTH-1:0]  vmem,
    output logic                 refrac,
    output logic [CNT_WIDTH-1:0] spike_cnt
);

    localparam int RC_W = (REFRAC > 0) ? $clog2(REFRAC + 1) : 1;
    localparam int EXT_W = VM_WIDTH + 2;

    localparam logic signed [EXT_W-1:0]    VM_MAX_E  = EXT_W'((2 ** (VM_WIDTH - 1)) - 1);
    localparam logic signed [EXT_W-1:0]    VM_MIN_E  = -VM_MAX_E - 1;
    localparam logic signed [VM_WIDTH-1:0] THRESH_V  = VM_WIDTH'(THRESH);
    localparam logic signed [VM_WIDTH-1:0] V_RESET_V = VM_WIDTH'(V_RESET);
    localparam logic [RC_W-1:0]            RC_LOAD   = RC_W'(REFRAC);
    localparam logic [RC_W-1:0]            RC_LAST   = RC_W'(1);

    typedef enum logic {
        INTEGRATE  = 1'b0,
        REFRACTORY = 1'b1
    } state_t;

    state_t                      state_q, state_d;
    logic signed [VM_WIDTH-1:0]  vmem_q, vmem_d;
    logic                        spike_q, spike_d;
    logic                        refrac_q, refrac_d;
    logic [RC_W-1:0]             rc_q, rc_d;
    logic [CNT_WIDTH-1:0]        cnt_q, cnt_d;

    logic signed [EXT_W-1:0]     vm_ext;
    logic signed [EXT_W-1:0]     leak_ext;
    logic signed [EXT_W-1:0]     syn_ext;
    logic signed [EXT_W-1:0]     sum_ext;
    logic signed [VM_WIDTH-1:0]  vmem_next;

    // Clamp the widened sum back onto the membrane rails.
    function automatic logic signed [VM_WIDTH-1:0] sat_vm(input logic signed [EXT_W-1:0] x);
        if (x > VM_MAX_E) begin
            return VM_MAX_E[VM_WIDTH-1:0];
        end else if (x < VM_MIN_E) begin
            return VM_MIN_E[VM_WIDTH-1:0];
        end
        return x[VM_WIDTH-1:0];
    endfunction

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] c);
        return (&c) ? c : c + 1'b1;
    endfunction

    // Leak/integrate arithmetic and next-state selection.
    always_comb begin
        state_d   = state_q;
        vmem_d    = vmem_q;
        spike_d   = 1'b0;
        refrac_d  = refrac_q;
        rc_d      = rc_q;
        cnt_d     = cnt_q;

        vm_ext    = vmem_q;
        leak_ext  = vmem_q >>> LEAK_SHIFT;
        syn_ext   = $signed(syn_in);
        sum_ext   = vm_ext - leak_ext + syn_ext;
        vmem_next = sat_vm(sum_ext);

        if (clear) begin
            state_d  = INTEGRATE;
            vmem_d   = V_RESET_V;
            refrac_d = 1'b0;
            rc_d     = '0;
            cnt_d    = '0;
        end else if (in_valid) begin
            case (state_q)
                INTEGRATE: begin
                    if (vmem_next >= THRESH_V) begin
                        vmem_d  = V_RESET_V;
                        spike_d = 1'b1;
                        cnt_d   = sat_inc(cnt_q);
                        if (REFRAC > 0) begin
                            state_d  = REFRACTORY;
                            rc_d     = RC_LOAD;
                            refrac_d = 1'b1;
                        end
                    end else begin
                        vmem_d = vmem_next;
                    end
                end
                REFRACTORY: begin
                    // Sample is discarded; the last one reopens integration.
                    vmem_d = V_RESET_V;
                    if (rc_q == RC_LAST) begin
                        state_d  = INTEGRATE;
                        refrac_d = 1'b0;
                        rc_d     = '0;
                    end else begin
                        rc_d = rc_q - 1'b1;
                    end
                end
                default: state_d = INTEGRATE;
            endcase
        end
    end

    // State and output registers, cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= INTEGRATE;
            vmem_q   <= '0;
            spike_q  <= 1'b0;
            refrac_q <= 1'b0;
            rc_q     <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            vmem_q   <= vmem_d;
            spike_q  <= spike_d;
            refrac_q <= refrac_d;
            rc_q     <= rc_d;
            cnt_q    <= cnt_d;
        end
    end

    assign spike_out = spike_q;
    assign vmem      = vmem_q;
    assign refrac    = refrac_q;
    assign spike_cnt = cnt_q;

endmodule
